// File: rtl/apb_arbiter_pkg.sv
// Shared types and limits for the APB round-robin arbiter.
package apb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        ACCESS   = 2'd2,
        COMPLETE = 2'd3
    } apb_arb_state_t;

    localparam int MAX_REQUESTERS = 8;

endpackage

// File: rtl/apb_arbiter_rr.sv
// Combinational round-robin pick: the first requester at or after ptr, wrapping modulo N.
module round_robin_arbiter
    import apb_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          grant_valid,
    output logic [PW-1:0] grant_idx
);

    int            idx;
    logic [PW-1:0] sel;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        sel         = '0;
        for (int k = MAX_REQUESTERS - 1; k >= 0; k--) begin
            if (k < N) begin
                idx = (int'(ptr) + k) % N;
                sel = PW'(idx);
                if (req[sel]) begin
                    grant_valid = 1'b1;
                    grant_idx   = sel;
                end
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one downstream APB completer among NUM_REQUESTERS upstream requesters, round-robin.
// Each grant is re-issued downstream with its own setup/access phases; the response returns registered.
module apb_arbiter
    import apb_arbiter_pkg::*;
#(
    parameter  int NUM_REQUESTERS = 2,
    parameter  int DATA_WIDTH     = 32,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int USER_WIDTH     = 0,
    localparam int UW             = (USER_WIDTH > 0) ? USER_WIDTH : 1,
    localparam int SW             = DATA_WIDTH / 8,
    localparam int PW             = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                     pclk,
    input  logic                                     preset,
    // upstream ports (block is completer)
    input  logic [NUM_REQUESTERS-1:0]                up_psel,
    input  logic [NUM_REQUESTERS-1:0]                up_pwrite,
    input  logic [NUM_REQUESTERS-1:0]                up_pwakeup,
    input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0] up_paddr,
    input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] up_pwdata,
    input  logic [NUM_REQUESTERS-1:0][2:0]           up_pprot,
    input  logic [NUM_REQUESTERS-1:0][SW-1:0]        up_pstrb,
    input  logic [NUM_REQUESTERS-1:0][UW-1:0]        up_pauser,
    input  logic [NUM_REQUESTERS-1:0][UW-1:0]        up_pwuser,
    output logic [NUM_REQUESTERS-1:0]                up_pready,
    output logic [NUM_REQUESTERS-1:0]                up_pslverr,
    output logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] up_prdata,
    output logic [NUM_REQUESTERS-1:0][UW-1:0]        up_pruser,
    output logic [NUM_REQUESTERS-1:0][UW-1:0]        up_pbuser,
    // downstream port (block is requester)
    output logic                                     down_pclk,
    output logic                                     down_preset_n,
    output logic                                     down_psel,
    output logic                                     down_penable,
    output logic                                     down_pwrite,
    output logic                                     down_pwakeup,
    output logic [ADDR_WIDTH-1:0]                    down_paddr,
    output logic [DATA_WIDTH-1:0]                    down_pwdata,
    output logic [2:0]                               down_pprot,
    output logic [SW-1:0]                            down_pstrb,
    output logic [UW-1:0]                            down_pauser,
    output logic [UW-1:0]                            down_pwuser,
    input  logic                                     down_pready,
    input  logic                                     down_pslverr,
    input  logic [DATA_WIDTH-1:0]                    down_prdata,
    input  logic [UW-1:0]                            down_pruser,
    input  logic [UW-1:0]                            down_pbuser
);

    apb_arb_state_t state_q, state_d;

    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]             grant_q, grant_d;
    logic                      abort_q, abort_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      write_q, write_d;
    logic [2:0]                prot_q, prot_d;
    logic [SW-1:0]             strb_q, strb_d;
    logic [UW-1:0]             auser_q, auser_d;
    logic [UW-1:0]             wuser_q, wuser_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      slverr_q, slverr_d;
    logic [UW-1:0]             ruser_q, ruser_d;
    logic [UW-1:0]             buser_q, buser_d;
    logic [NUM_REQUESTERS-1:0] pready_q, pready_d;

    logic          win_vld;
    logic [PW-1:0] win_idx;

    round_robin_arbiter #(.N(NUM_REQUESTERS)) u_rr (
        .req         (up_psel),
        .ptr         (rr_ptr_q),
        .grant_valid (win_vld),
        .grant_idx   (win_idx)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            abort_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            prot_q   <= '0;
            strb_q   <= '0;
            auser_q  <= '0;
            wuser_q  <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            ruser_q  <= '0;
            buser_q  <= '0;
            pready_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            abort_q  <= abort_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            prot_q   <= prot_d;
            strb_q   <= strb_d;
            auser_q  <= auser_d;
            wuser_q  <= wuser_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
            ruser_q  <= ruser_d;
            buser_q  <= buser_d;
            pready_q <= pready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (win_vld) state_d = SETUP;
            SETUP:    state_d = ACCESS;
            ACCESS:   if (down_pready) state_d = COMPLETE;
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        abort_d  = abort_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        prot_d   = prot_q;
        strb_d   = strb_q;
        auser_d  = auser_q;
        wuser_d  = wuser_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        ruser_d  = ruser_q;
        buser_d  = buser_q;
        pready_d = '0;

        if (state_q == IDLE && win_vld) begin
            grant_d  = win_idx;
            rr_ptr_d = (win_idx == PW'(NUM_REQUESTERS - 1)) ? '0 : win_idx + PW'(1);
            abort_d  = 1'b0;
            addr_d   = up_paddr[win_idx];
            wdata_d  = up_pwdata[win_idx];
            write_d  = up_pwrite[win_idx];
            prot_d   = up_pprot[win_idx];
            strb_d   = up_pstrb[win_idx];
            auser_d  = up_pauser[win_idx];
            wuser_d  = up_pwuser[win_idx];
        end

        // A requester that lets go mid-transfer forfeits the response; the bus cycle still finishes.
        if ((state_q == SETUP || state_q == ACCESS) && !up_psel[grant_q]) begin
            abort_d = 1'b1;
        end

        if (state_q == ACCESS && down_pready) begin
            rdata_d           = down_prdata;
            slverr_d          = down_pslverr;
            ruser_d           = down_pruser;
            buser_d           = down_pbuser;
            pready_d[grant_q] = !abort_q && up_psel[grant_q];
        end
    end

    always_comb begin
        down_psel    = 1'b0;
        down_penable = 1'b0;
        unique case (state_q)
            SETUP:   down_psel = 1'b1;
            ACCESS: begin
                down_psel    = 1'b1;
                down_penable = 1'b1;
            end
            default: ;
        endcase
    end

    assign down_pclk     = pclk;
    assign down_preset_n = ~preset;
    assign down_pwakeup  = (|up_pwakeup) || (state_q != IDLE);
    assign down_paddr    = addr_q;
    assign down_pwdata   = wdata_q;
    assign down_pwrite   = write_q;
    assign down_pprot    = prot_q;
    assign down_pstrb    = strb_q;
    assign down_pauser   = auser_q;
    assign down_pwuser   = wuser_q;

    assign up_pready = pready_q;

    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            up_prdata[i]  = pready_q[i] ? rdata_q : '0;
            up_pslverr[i] = pready_q[i] && slverr_q;
            up_pruser[i]  = pready_q[i] ? ruser_q : '0;
            up_pbuser[i]  = pready_q[i] ? buser_q : '0;
        end
    end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Round-robin arbiter sharing one downstream APB completer among NUM_REQUESTERS upstream APB requesters. Each upstream port presents a completer-side APB interface. The block serialises transfers, re-issues each granted transfer on the downstream bus with its own setup/access phases, and returns the registered response to the winner. It sits between CPU/DMA-side APB masters and a single peripheral or register bank.

## Interface
- NUM_REQUESTERS, 2: upstream port count, 2–8.
- DATA_WIDTH, 32: APB data width, 8/16/32; all ports match.
- ADDR_WIDTH, 32: APB address width; all ports match.
- USER_WIDTH, 0: pauser/pwuser/pruser/pbuser width; all ports match.
- pclk  in  1  Single clock for the block and all bus ports.
- preset  in  1  Synchronous, active-high reset.
- up[NUM_REQUESTERS]  APB.completer  -  Upstream ports; the block is completer.
- down  APB.requester  -  Downstream port; the block is requester. down.pclk = pclk, down.preset_n = ~preset.

## Operation
- Request i = up[i].psel. Requests are sampled only in IDLE.
- Round-robin: priority pointer rr_ptr resets to 0. The winner is the first requesting index at or after rr_ptr, wrapping modulo NUM_REQUESTERS. On grant, rr_ptr = winner+1, wrapping.
- FSM states: IDLE, SETUP, ACCESS, COMPLETE.
  - IDLE: if any request is present, latch grant, paddr, pwrite, pwdata, pprot, pstrb, pauser and pwuser from the winner, then go to SETUP. Otherwise stay in IDLE.
  - SETUP: down.psel=1, down.penable=0. Go to ACCESS unconditionally.
  - ACCESS: down.psel=1, down.penable=1. Hold until down.pready=1. On that edge, register prdata, pslverr, pruser and pbuser, then go to COMPLETE.
  - COMPLETE: down.psel=0. up[grant].pready=1 with the registered response for exactly one cycle. Go to IDLE.
- Downstream address and control come only from latched registers. They are stable from SETUP through ACCESS.
- Non-granted upstream ports: pready=0, prdata=0, pslverr=0, pruser=0, pbuser=0. Their pending requests wait, held with pready low.
- down.pwakeup = OR of all up[i].pwakeup, OR (state != IDLE).
- If the granted upstream drops psel before COMPLETE (protocol violation), the downstream transfer still completes. The response is discarded, up[grant].pready stays 0, and the FSM returns to IDLE.
- Reset at any state forces IDLE, rr_ptr=0, and all outputs to their reset values. A downstream transfer in flight is abandoned.

## Timing
- Reset values: down.psel=0, down.penable=0, down.paddr/pwdata/pwrite/pprot/pstrb/pauser/pwuser=0. All up[i].pready=0, prdata=0, pslverr=0, pruser=0, pbuser=0.
- Zero-wait downstream: the upstream setup phase is at cycle 0. Downstream setup is at cycle 1, downstream access at cycle 2, and upstream pready=1 at cycle 3.
- Each downstream wait state adds one cycle.
- A request asserted in the cycle COMPLETE is active is granted at the next IDLE cycle. Back-to-back transfers therefore occupy 4 cycles each (IDLE, SETUP, ACCESS, COMPLETE).
- Simultaneous requests in IDLE are resolved in the same cycle by rr_ptr. No request starves: worst-case wait is (NUM_REQUESTERS-1) transfers.
- All upstream outputs are registered. There is no combinational path from down.* to up[*].*.

## Structure
- Package apb_arbiter_pkg holds:
  - typedef enum logic[1:0] apb_arb_state_t {IDLE, SETUP, ACCESS, COMPLETE};
  - localparam MAX_REQUESTERS = 8.
- Sub-module round_robin_arbiter (parameter N) is purely combinational:
  - Inputs: req[N-1:0], ptr[$clog2(N)-1:0].
  - Outputs: grant_valid, grant_idx.
- apb_arbiter owns the FSM, the latch registers, rr_ptr and the response muxing.

## Test plan
- Single write: up[0] writes paddr=0x10, pwdata=0xDEADBEEF with a zero-wait downstream. down sees psel at cycle 1 and penable at cycle 2 with the same address and data. up[0].pready=1 at cycle 3, pslverr=0.
- Read with 2 downstream wait states, down.prdata=0x12345678, pslverr=1. up[1] sees pready at cycle 5 with prdata=0x12345678 and pslverr=1. up[0] outputs stay 0 throughout.
- Simultaneous requests: up[0] and up[1] request continuously after reset. Grants follow 0,1,0,1, each transfer is 4 cycles, and no port gets two consecutive grants.
- Upstream drops psel mid-transfer: up[0] deasserts psel during ACCESS. down completes normally, up[0].pready never asserts, and the FSM is back in IDLE the cycle after COMPLETE.
- Reset mid-ACCESS: preset pulses while down.penable=1. On the next cycle all outputs equal their reset values and rr_ptr=0. A subsequent up[1]-only request is granted normally.
- NUM_REQUESTERS=4 with requests on ports 1 and 3 only, rr_ptr=2. The grant order is 3,1,3,1 and wraps correctly.
